// File: rtl/irr_capture.sv
// Interrupt request capture: synchronizes the IR pins, latches edge- or level-triggered
// requests into irr_q, and applies the mask register to drive the priority resolver.
module irr_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] IR,
  input  logic       init_wr,
  input  logic       ltim,
  input  logic       imr_wr,
  input  logic [7:0] imr_din,
  input  logic       resetIRRbit,
  input  logic [7:0] clr_vec,
  output logic [7:0] IRR,
  output logic [7:0] IMR,
  output logic [7:0] irr_raw,
  output logic       INT_req
);

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_d [SYNC_STAGES];
  logic [7:0] ir_s;
  logic [7:0] ir_d_q, ir_d_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] imr_q, imr_d;
  logic       level_q, level_d;
  logic [7:0] clr_mask;
  logic [7:0] set_vec;

  always_comb begin
    sync_d[0] = IR;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign ir_s = sync_q[SYNC_STAGES-1];

  // A clear in the same cycle as a set wins; level mode simply reloads next cycle.
  always_comb begin
    ir_d_d   = ir_s;
    irr_d    = irr_q;
    imr_d    = imr_q;
    level_d  = level_q;
    clr_mask = resetIRRbit ? clr_vec : 8'h00;
    set_vec  = ir_s & ~ir_d_q;

    if (level_q) begin
      irr_d = ir_s & ~clr_mask;
    end else begin
      irr_d = (irr_q | set_vec) & ~clr_mask;
    end

    if (imr_wr) begin
      imr_d = imr_din;
    end

    if (init_wr) begin
      irr_d   = 8'h00;
      imr_d   = 8'h00;
      level_d = ltim;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 8'h00;
      end
      ir_d_q  <= 8'h00;
      irr_q   <= 8'h00;
      imr_q   <= 8'h00;
      level_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      ir_d_q  <= ir_d_d;
      irr_q   <= irr_d;
      imr_q   <= imr_d;
      level_q <= level_d;
    end
  end

  assign irr_raw = irr_q;
  assign IMR     = imr_q;
  assign IRR     = irr_q & ~imr_q;
  assign INT_req = |IRR;

endmodule

// File: tb/tb_irr_capture.sv
// Directed table-driven bench for irr_capture: each vector drives one cycle of inputs
// and compares the registered outputs just after the following rising edge.
module tb_irr_capture;

  typedef struct {
    logic [7:0] ir;
    logic       init_wr;
    logic       ltim;
    logic       imr_wr;
    logic [7:0] imr_din;
    logic       rst_bit;
    logic [7:0] clr_vec;
    logic [7:0] exp_raw;
    logic [7:0] exp_irr;
    logic [7:0] exp_imr;
    logic       exp_int;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir;
  logic       init_wr;
  logic       ltim;
  logic       imr_wr;
  logic [7:0] imr_din;
  logic       reset_irr_bit;
  logic [7:0] clr_vec;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [7:0] irr_raw;
  logic       int_req;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  irr_capture #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IR          (ir),
    .init_wr     (init_wr),
    .ltim        (ltim),
    .imr_wr      (imr_wr),
    .imr_din     (imr_din),
    .resetIRRbit (reset_irr_bit),
    .clr_vec     (clr_vec),
    .IRR         (irr),
    .IMR         (imr),
    .irr_raw     (irr_raw),
    .INT_req     (int_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input logic [7:0] v_ir, input logic v_init, input logic v_ltim,
                        input logic v_imrwr, input logic [7:0] v_imrdin,
                        input logic v_rst, input logic [7:0] v_clr,
                        input logic [7:0] e_raw, input logic [7:0] e_irr,
                        input logic [7:0] e_imr, input logic e_int);
    vec_t v;
    v.ir = v_ir; v.init_wr = v_init; v.ltim = v_ltim; v.imr_wr = v_imrwr;
    v.imr_din = v_imrdin; v.rst_bit = v_rst; v.clr_vec = v_clr;
    v.exp_raw = e_raw; v.exp_irr = e_irr; v.exp_imr = e_imr; v.exp_int = e_int;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] e_raw, input logic [7:0] e_irr,
                             input logic [7:0] e_imr, input logic e_int);
    checks++;
    if (irr_raw !== e_raw || irr !== e_irr || imr !== e_imr || int_req !== e_int) begin
      errors++;
      $display("[TB] FAIL %s: got raw=%h IRR=%h IMR=%h INT=%b, expected raw=%h IRR=%h IMR=%h INT=%b",
               name, irr_raw, irr, imr, int_req, e_raw, e_irr, e_imr, e_int);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    ir            = v.ir;
    init_wr       = v.init_wr;
    ltim          = v.ltim;
    imr_wr        = v.imr_wr;
    imr_din       = v.imr_din;
    reset_irr_bit = v.rst_bit;
    clr_vec       = v.clr_vec;
    @(posedge clk);
    #1;
    checkOutput(name, v.exp_raw, v.exp_irr, v.exp_imr, v.exp_int);
  endtask

  task automatic step(input logic [7:0] v_ir, input logic v_init, input logic v_ltim,
                      input logic v_imrwr, input logic [7:0] v_imrdin,
                      input logic [7:0] e_raw, input logic [7:0] e_imr, input string name);
    vec_t v;
    v.ir = v_ir; v.init_wr = v_init; v.ltim = v_ltim; v.imr_wr = v_imrwr;
    v.imr_din = v_imrdin; v.rst_bit = 1'b0; v.clr_vec = 8'h00;
    v.exp_raw = e_raw; v.exp_irr = e_raw & ~e_imr; v.exp_imr = e_imr;
    v.exp_int = |(e_raw & ~e_imr);
    applyStimulus(v, name);
  endtask

  initial begin
    // Edge mode: one-cycle pulse on IR2, then held
    addVec(8'h04, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h00, 1);
    addVec(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h00, 1);
    // Clear while held high, then re-arm via low-then-high
    addVec(8'h04, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h00, 1);
    addVec(8'h04, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h00, 1);
    addVec(8'h04, 0, 0, 0, 8'h00, 1, 8'h04, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h04, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h04, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h04, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h04, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h00, 1);
    addVec(8'h04, 0, 0, 0, 8'h00, 1, 8'h00, 8'h04, 8'h04, 8'h00, 1);
    // Masking: masked IR0 latches but stays off IRR until unmasked
    addVec(8'h04, 0, 0, 1, 8'h01, 0, 8'h00, 8'h04, 8'h04, 8'h01, 1);
    addVec(8'h05, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h01, 1);
    addVec(8'h05, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h01, 1);
    addVec(8'h05, 0, 0, 0, 8'h00, 1, 8'h04, 8'h01, 8'h00, 8'h01, 0);
    addVec(8'h05, 0, 0, 1, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1);
    // Many edges at once, then a non-one-hot clear
    addVec(8'hFF, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1);
    addVec(8'hFF, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1);
    addVec(8'hFF, 0, 0, 0, 8'h00, 0, 8'h00, 8'hFB, 8'hFB, 8'h00, 1);
    addVec(8'hFF, 0, 0, 0, 8'h00, 1, 8'h0A, 8'hF1, 8'hF1, 8'h00, 1);
    addVec(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'hF1, 8'hF1, 8'h00, 1);
    // Level mode
    addVec(8'h81, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h81, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h81, 0, 0, 0, 8'h00, 0, 8'h00, 8'h81, 8'h81, 8'h00, 1);
    addVec(8'h01, 0, 0, 0, 8'h00, 0, 8'h00, 8'h81, 8'h81, 8'h00, 1);
    addVec(8'h01, 0, 0, 0, 8'h00, 0, 8'h00, 8'h81, 8'h81, 8'h00, 1);
    addVec(8'h01, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1);
    addVec(8'h01, 0, 0, 0, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    addVec(8'h01, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1);
    // ltim without init_wr is ignored: still level mode, so the bit follows IR down
    addVec(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1);
    addVec(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1);
    addVec(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    ir = 8'h00; init_wr = 0; ltim = 0; imr_wr = 0; imr_din = 8'h00;
    reset_irr_bit = 0; clr_vec = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, "idle");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // init_wr beats imr_wr and a same-cycle edge; back to edge mode
    step(8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, "init_edge_mode");
    step(8'h10, 0, 0, 0, 8'h00, 8'h00, 8'h00, "pre_edge_a");
    step(8'h10, 0, 0, 0, 8'h00, 8'h00, 8'h00, "pre_edge_b");
    step(8'h10, 1, 0, 1, 8'hFF, 8'h00, 8'h00, "init_priority");
    step(8'h10, 0, 0, 0, 8'h00, 8'h00, 8'h00, "init_no_spurious");

    // Async reset with all requests pending, IR held high through release
    step(8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, "pre_ff_a");
    step(8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, "ff_sync1");
    step(8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, "ff_sync2");
    step(8'hFF, 0, 0, 0, 8'h00, 8'hFF, 8'h00, "ff_latched");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, "post_reset_e1");
    step(8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, "post_reset_e2");
    step(8'hFF, 0, 0, 0, 8'h00, 8'hFF, 8'h00, "post_reset_e3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
